// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light phase sequencer: state encoding,
// lamp patterns and the demand scan used to pick the next phase to serve.
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_WALK   = 2'd3
  } tlc_state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int MAX_PHASES = 8;

  // First phase after 'start' (with wrap) whose demand is set; phase 0 is on
  // permanent recall, so the scan always ends at 0 at the latest.
  function automatic logic [2:0] next_phase(input logic [MAX_PHASES-1:0] demand,
                                            input int n_phases,
                                            input logic [2:0] start);
    logic [2:0] result;
    logic       found;
    int         j;
    result = 3'd0;
    found  = 1'b0;
    for (int k = 1; k <= MAX_PHASES; k++) begin
      j = (int'(start) + k) % n_phases;
      if (!found && (k <= n_phases) && ((j == 0) || demand[j])) begin
        result = j[2:0];
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/tlc_interval_timer.sv
// Down-counting interval timer: loaded with D-1, expires on the tick that
// finds it at zero, so an interval lasts exactly D ticks.
module tlc_interval_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  input  logic               tick,
  output logic               expired
);

  logic [TIMER_W-1:0] count_reg;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (tick && (count_reg != '0)) begin
      count_reg <= count_reg - TIMER_W'(1);
    end
  end

  assign expired = tick && (count_reg == '0);

endmodule

// File: rtl/tlc_phase_sequencer.sv
// Demand-actuated N-approach traffic-light sequencer with phase skipping,
// bounded green extension, all-red clearance and a latched walk interval.
module tlc_phase_sequencer
  import tlc_pkg::*;
#(
  parameter int N_PHASES = 3,
  parameter int TIMER_W  = 8,
  parameter int T_BASE   = 6,
  parameter int T_MAIN0  = 12,
  parameter int T_EXT    = 3,
  parameter int T_YEL    = 2,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 4,
  parameter int MAX_EXT  = 1
) (
  input  logic                        clk,
  input  logic                        Reset_n,
  input  logic                        tick,
  input  logic                        prog,
  input  logic [N_PHASES-1:0]         sensor,
  input  logic                        walk_req,
  output logic [3*N_PHASES-1:0]       lights,
  output logic                        walk,
  output logic [$clog2(N_PHASES)-1:0] phase,
  output logic                        walk_pending
);

  localparam int PH_W  = $clog2(N_PHASES);
  localparam int EXT_W = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;

  localparam logic [TIMER_W-1:0] D_BASE     = TIMER_W'(T_BASE - 1);
  localparam logic [TIMER_W-1:0] D_MAIN0    = TIMER_W'(T_MAIN0 - 1);
  localparam logic [TIMER_W-1:0] D_EXT      = TIMER_W'(T_EXT - 1);
  localparam logic [TIMER_W-1:0] D_YEL      = TIMER_W'(T_YEL - 1);
  localparam logic [TIMER_W-1:0] D_ALLRED   = TIMER_W'(T_ALLRED - 1);
  localparam logic [TIMER_W-1:0] D_WALK     = TIMER_W'(T_WALK - 1);
  localparam logic [TIMER_W-1:0] D_ALLRED_2 = TIMER_W'((T_ALLRED > 1) ? (T_ALLRED - 2) : 0);

  tlc_state_t                state_reg, state_next;
  logic [PH_W-1:0]           phase_reg, phase_next;
  logic [PH_W-1:0]           nxt_reg, nxt_next;
  logic                      nxt_walk_reg, nxt_walk_next;
  logic [EXT_W-1:0]          ext_cnt_reg, ext_cnt_next;
  logic [N_PHASES-1:0]       demand_reg, demand_next;
  logic                      walk_pending_reg, walk_pending_next;
  logic                      first_reg, first_next;
  logic                      restart_reg, restart_next;
  logic [3*N_PHASES-1:0]     lights_reg, lights_next;
  logic                      walk_reg, walk_next;

  logic [N_PHASES-1:0]       demand_set, demand_clr;
  logic [MAX_PHASES-1:0]     demand_scan;
  logic                      walk_clr;
  logic                      tmr_load, tmr_expired, expiry;
  logic [TIMER_W-1:0]        tmr_value;

  tlc_interval_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk     (clk),
    .Reset_n (Reset_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .tick    (tick),
    .expired (tmr_expired)
  );

  // A phase being served (green or yellow) does not latch its own demand.
  for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_demand_set
    assign demand_set[gi] = sensor[gi] &&
        !(((state_reg == ST_GREEN) || (state_reg == ST_YELLOW)) && (phase_reg == PH_W'(gi)));
  end

  always_comb begin
    demand_scan = '0;
    demand_scan[N_PHASES-1:0] = demand_reg;
  end

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    nxt_next      = nxt_reg;
    nxt_walk_next = nxt_walk_reg;
    ext_cnt_next  = ext_cnt_reg;
    first_next    = first_reg;
    restart_next  = restart_reg;
    demand_clr    = '0;
    walk_clr      = 1'b0;
    tmr_load      = 1'b0;
    tmr_value     = '0;
    expiry        = tmr_expired;

    // The timer comes out of reset at zero; the first all-red tick stands in
    // for the missing T_ALLRED-1 preload.
    if (restart_reg) begin
      expiry = tick && (T_ALLRED == 1);
      if (tick) begin
        restart_next = 1'b0;
        if (T_ALLRED > 1) begin
          tmr_load  = 1'b1;
          tmr_value = D_ALLRED_2;
        end
      end
    end

    case (state_reg)
      ST_ALLRED: begin
        if (expiry) begin
          tmr_load = 1'b1;
          if (nxt_walk_reg) begin
            state_next = ST_WALK;
            tmr_value  = D_WALK;
            walk_clr   = 1'b1;
          end else begin
            state_next          = ST_GREEN;
            phase_next          = nxt_reg;
            ext_cnt_next        = '0;
            first_next          = 1'b0;
            demand_clr[nxt_reg] = 1'b1;
            tmr_value           = (first_reg && (nxt_reg == '0)) ? D_MAIN0 : D_BASE;
          end
        end
      end
      ST_GREEN: begin
        if (expiry) begin
          tmr_load = 1'b1;
          if (sensor[phase_reg] && (int'(ext_cnt_reg) < MAX_EXT)) begin
            tmr_value    = D_EXT;
            ext_cnt_next = ext_cnt_reg + EXT_W'(1);
          end else if ((phase_reg == '0) && (demand_reg[N_PHASES-1:1] == '0) && !walk_pending_reg) begin
            tmr_value = D_BASE;
          end else begin
            state_next = ST_YELLOW;
            tmr_value  = D_YEL;
          end
        end
      end
      ST_YELLOW: begin
        if (expiry) begin
          state_next    = ST_ALLRED;
          tmr_load      = 1'b1;
          tmr_value     = D_ALLRED;
          nxt_walk_next = (phase_reg == '0) && walk_pending_reg;
          nxt_next      = PH_W'(next_phase(demand_scan, N_PHASES, 3'(phase_reg)));
        end
      end
      ST_WALK: begin
        if (expiry) begin
          state_next    = ST_ALLRED;
          tmr_load      = 1'b1;
          tmr_value     = D_ALLRED;
          nxt_walk_next = 1'b0;
          nxt_next      = PH_W'(next_phase(demand_scan, N_PHASES, 3'd0));
        end
      end
      default: state_next = ST_ALLRED;
    endcase

    demand_next       = (demand_reg & ~demand_clr) | demand_set;
    walk_pending_next = (walk_pending_reg & ~walk_clr) | walk_req;

    if (prog) begin
      state_next        = ST_ALLRED;
      phase_next        = '0;
      nxt_next          = '0;
      nxt_walk_next     = 1'b0;
      ext_cnt_next      = '0;
      first_next        = 1'b1;
      restart_next      = 1'b0;
      demand_next       = '0;
      walk_pending_next = 1'b0;
      tmr_load          = 1'b1;
      tmr_value         = D_ALLRED;
    end
  end

  // Lamps are decoded from the next state so they are registered with it.
  for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_lamps
    assign lights_next[3*gi +: 3] =
        ((state_next == ST_GREEN)  && (phase_next == PH_W'(gi))) ? LAMP_G :
        ((state_next == ST_YELLOW) && (phase_next == PH_W'(gi))) ? LAMP_Y : LAMP_R;
  end
  assign walk_next = (state_next == ST_WALK);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg        <= ST_ALLRED;
      phase_reg        <= '0;
      nxt_reg          <= '0;
      nxt_walk_reg     <= 1'b0;
      ext_cnt_reg      <= '0;
      demand_reg       <= '0;
      walk_pending_reg <= 1'b0;
      first_reg        <= 1'b1;
      restart_reg      <= 1'b1;
      lights_reg       <= {N_PHASES{LAMP_R}};
      walk_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      phase_reg        <= phase_next;
      nxt_reg          <= nxt_next;
      nxt_walk_reg     <= nxt_walk_next;
      ext_cnt_reg      <= ext_cnt_next;
      demand_reg       <= demand_next;
      walk_pending_reg <= walk_pending_next;
      first_reg        <= first_next;
      restart_reg      <= restart_next;
      lights_reg       <= lights_next;
      walk_reg         <= walk_next;
    end
  end

  assign lights       = lights_reg;
  assign walk         = walk_reg;
  assign phase        = phase_reg;
  assign walk_pending = walk_pending_reg;

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Randomized scoreboard bench for tlc_phase_sequencer: a behavioural model
// predicts every cycle's outputs, a monitor pops and compares them.
module tb_tlc_phase_sequencer;

  localparam int N        = 3;
  localparam int T_BASE   = 4;
  localparam int T_MAIN0  = 8;
  localparam int T_EXT    = 2;
  localparam int T_YEL    = 2;
  localparam int T_ALLRED = 1;
  localparam int T_WALK   = 3;
  localparam int MAX_EXT  = 1;

  logic           clk = 1'b0;
  logic           Reset_n = 1'b0;
  logic           tick = 1'b0;
  logic           prog = 1'b0;
  logic [N-1:0]   sensor = '0;
  logic           walk_req = 1'b0;
  logic [3*N-1:0] lights;
  logic           walk;
  logic [1:0]     phase;
  logic           walk_pending;

  always #5 clk = ~clk;

  tlc_phase_sequencer #(
    .N_PHASES(N), .TIMER_W(8), .T_BASE(T_BASE), .T_MAIN0(T_MAIN0), .T_EXT(T_EXT),
    .T_YEL(T_YEL), .T_ALLRED(T_ALLRED), .T_WALK(T_WALK), .MAX_EXT(MAX_EXT)
  ) dut (
    .clk(clk), .Reset_n(Reset_n), .tick(tick), .prog(prog), .sensor(sensor),
    .walk_req(walk_req), .lights(lights), .walk(walk), .phase(phase),
    .walk_pending(walk_pending)
  );

  typedef struct packed {
    logic [3*N-1:0] lights;
    logic           walk;
    logic [1:0]     phase;
    logic           walk_pending;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: mode, served phase, pending target (-1 = walk),
  // ticks left in the current interval, extensions used, latched requests.
  typedef enum int {M_ALLRED, M_GREEN, M_YELLOW, M_WALK} mode_t;
  mode_t m_mode;
  int    m_phase, m_next, m_left, m_ext;
  bit    m_first, m_wpend;
  bit    m_dem[N];

  task automatic model_reset();
    m_mode  = M_ALLRED;
    m_phase = 0;
    m_next  = 0;
    m_left  = T_ALLRED;
    m_ext   = 0;
    m_first = 1'b1;
    m_wpend = 1'b0;
    for (int i = 0; i < N; i++) m_dem[i] = 1'b0;
  endtask

  function automatic int scan_from(int start);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (start + k) % N;
      if (j == 0 || m_dem[j]) return j;
    end
    return 0;
  endfunction

  function automatic bit side_demand();
    bit any;
    any = 1'b0;
    for (int i = 1; i < N; i++) any = any | m_dem[i];
    return any;
  endfunction

  task automatic model_step(bit tk, bit pg, bit [N-1:0] sen, bit wr);
    bit set_d[N];
    bit clr_d[N];
    bit wclr;
    if (pg) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      set_d[i] = sen[i] && !((m_mode == M_GREEN || m_mode == M_YELLOW) && m_phase == i);
      clr_d[i] = 1'b0;
    end
    wclr = 1'b0;
    if (tk) begin
      if (m_left > 1) begin
        m_left--;
      end else begin
        case (m_mode)
          M_ALLRED: begin
            if (m_next < 0) begin
              m_mode = M_WALK;
              m_left = T_WALK;
              wclr   = 1'b1;
            end else begin
              m_mode  = M_GREEN;
              m_phase = m_next;
              m_left  = (m_first && m_next == 0) ? T_MAIN0 : T_BASE;
              m_first = 1'b0;
              m_ext   = 0;
              clr_d[m_next] = 1'b1;
            end
          end
          M_GREEN: begin
            if (sen[m_phase] && m_ext < MAX_EXT) begin
              m_left = T_EXT;
              m_ext++;
            end else if (m_phase == 0 && !side_demand() && !m_wpend) begin
              m_left = T_BASE;
            end else begin
              m_mode = M_YELLOW;
              m_left = T_YEL;
            end
          end
          M_YELLOW: begin
            m_next = (m_phase == 0 && m_wpend) ? -1 : scan_from(m_phase);
            m_mode = M_ALLRED;
            m_left = T_ALLRED;
          end
          default: begin
            m_next = scan_from(0);
            m_mode = M_ALLRED;
            m_left = T_ALLRED;
          end
        endcase
      end
    end
    for (int i = 0; i < N; i++) m_dem[i] = (m_dem[i] && !clr_d[i]) || set_d[i];
    m_wpend = (m_wpend && !wclr) || wr;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    for (int i = 0; i < N; i++) begin
      if (m_mode == M_GREEN && m_phase == i)       o.lights[3*i +: 3] = 3'b001;
      else if (m_mode == M_YELLOW && m_phase == i) o.lights[3*i +: 3] = 3'b010;
      else                                         o.lights[3*i +: 3] = 3'b100;
    end
    o.walk         = (m_mode == M_WALK);
    o.phase        = 2'(m_phase);
    o.walk_pending = m_wpend;
    return o;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, req);
    end
  endtask

  // Inputs change on the falling edge; the model steps on what the DUT will
  // sample at the next rising edge.
  task automatic apply_cycle();
    if (Reset_n) model_step(tick, prog, sensor, walk_req);
    else         model_reset();
    exp_q.push_back(model_obs());
  endtask

  task automatic run_cycles(int n, int tick_pct, int sens_pct, int prog_den);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      Reset_n  = 1'b1;
      tick     = ($urandom_range(99) < tick_pct);
      prog     = ($urandom_range(prog_den - 1) == 0);
      walk_req = ($urandom_range(39) == 0);
      for (int i = 0; i < N; i++) sensor[i] = ($urandom_range(99) < sens_pct);
      apply_cycle();
    end
  endtask

  task automatic hold_reset(int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      Reset_n  = 1'b0;
      tick     = 1'b0;
      prog     = 1'b0;
      walk_req = 1'b0;
      sensor   = '0;
      apply_cycle();
    end
  endtask

  // Monitor: one expected observation per rising edge.
  obs_t mon_exp, mon_prev;
  initial begin
    mon_prev = '0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        cmp("lights", 32'(lights), 32'(mon_exp.lights));
        cmp("walk", 32'(walk), 32'(mon_exp.walk));
        cmp("phase", 32'(phase), 32'(mon_exp.phase));
        cmp("walk_pending", 32'(walk_pending), 32'(mon_exp.walk_pending));
        if (mon_exp != mon_prev)
          $display("t=%0t lights=%b walk=%b phase=%0d walk_pending=%b",
                   $time, lights, walk, phase, walk_pending);
        mon_prev = mon_exp;
      end
    end
  end

  initial begin
    bit reached;
    model_reset();
    hold_reset(3);
    run_cycles(600, 100, 20, 300);
    run_cycles(600, 60, 5, 400);
    run_cycles(300, 100, 1, 1000);

    // Drive toward a WALK interval, then drop reset between clock edges.
    reached = 1'b0;
    for (int c = 0; c < 400 && !reached; c++) begin
      @(negedge clk);
      Reset_n  = 1'b1;
      tick     = 1'b1;
      prog     = 1'b0;
      walk_req = 1'b1;
      sensor   = N'($urandom_range(7));
      apply_cycle();
      if (m_mode == M_WALK && m_left >= 2) reached = 1'b1;
    end
    cmp("walk_reached", 32'(reached), 32'd1);
    @(posedge clk);
    #3;
    Reset_n = 1'b0;
    #1;
    cmp("async_lights", 32'(lights), 32'(9'b100100100));
    cmp("async_walk", 32'(walk), 32'd0);
    cmp("async_phase", 32'(phase), 32'd0);
    cmp("async_walk_pending", 32'(walk_pending), 32'd0);
    model_reset();
    hold_reset(2);
    run_cycles(400, 100, 15, 150);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain queue_left=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
